// File: rtl/md_pkg.sv
// md_pkg: shared pair packing, empty-slot constant and arbiter state encoding.
//   PAIR_W    : full pair width (neighbor + reference)
//   PART_W    : width of one half (neighbor or reference)
//   EMPTY_BIT : position of the empty flag inside a half
package md_pkg;
    localparam int PAIR_W = 194;
    localparam int PART_W = 97;
    localparam int EMPTY_BIT = 96;

    typedef struct packed {
        logic [PART_W-1:0] nbr;
        logic [PART_W-1:0] ref_part;
    } pair_t;

    // Both halves flagged empty, payload zero.
    localparam pair_t EMPTY_PAIR = pair_t'({1'b1, {(PART_W-1){1'b0}}, 1'b1, {(PART_W-1){1'b0}}});

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} arb_state_t;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin grant over N eligible requesters.
//   eligible : requesters that may be granted this cycle
//   ptr      : last granted index; search starts at ptr+1
//   grant    : one-hot grant
//   idx      : encoded index of the grant
//   any      : a grant was issued
module rr_grant #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] c;

    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        c = '0;
        for (int k = 1; k <= N; k++) begin
            c = IW'((int'(ptr) + k) % N);
            if (!any && eligible[c]) begin
                any = 1'b1;
                idx = c;
            end
        end
        grant[idx] = any;
    end
endmodule

// File: rtl/pair_arbiter.sv
// pair_arbiter: round-robin scheduler feeding one force pipeline from NUM_REQ pair sources.
//   clk, reset   : clock, synchronous active-low reset
//   start        : begin a run (honoured in IDLE only)
//   req_valid    : requester i presents a pair
//   req_pair     : NUM_REQ packed pairs, slice i at [PAIR_W*i +: PAIR_W]
//   req_done     : requester i has no further pairs this run
//   req_ready    : one-hot combinational grant
//   pipe_in      : registered pipeline input, empty pair when nothing granted
//   busy         : high in RUN and DRAIN
//   done         : one-cycle pulse once the pipeline has drained
//   pairs_issued : saturating count of pairs transferred this run
module pair_arbiter
    import md_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 20,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*PAIR_W-1:0] req_pair,
    input  logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [PAIR_W-1:0]         pipe_in,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          pairs_issued
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int DW = $clog2(PIPE_LAT + 1);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] fin, fin_nxt, eligible, grant;
    logic [IW-1:0]      rr, gnt_idx;
    logic               gnt_any, all_fin;
    logic [DW-1:0]      drain_cnt;

    always_comb begin
        eligible = (state == ST_RUN) ? (req_valid & ~fin) : '0;
        // A requester still presenting a pair is not finished even if done is high.
        fin_nxt = fin | (req_done & ~req_valid);
        all_fin = &fin_nxt;
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nxt = all_fin ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt = (drain_cnt == '0) ? ST_FIN : ST_DRAIN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    rr_grant #(.N(NUM_REQ)) u_rr (
        .eligible(eligible),
        .ptr(rr),
        .grant(grant),
        .idx(gnt_idx),
        .any(gnt_any)
    );

    assign req_ready = grant;
    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_FIN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            pipe_in <= EMPTY_PAIR;
            pairs_issued <= '0;
            fin <= '0;
            rr <= IW'(NUM_REQ - 1);
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            pipe_in <= gnt_any ? req_pair[gnt_idx*PAIR_W +: PAIR_W] : EMPTY_PAIR;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pairs_issued <= '0;
                        fin <= '0;
                        rr <= IW'(NUM_REQ - 1);
                    end
                end
                ST_RUN: begin
                    fin <= fin_nxt;
                    if (gnt_any) begin
                        rr <= gnt_idx;
                        pairs_issued <= (&pairs_issued) ? pairs_issued : pairs_issued + 1'b1;
                    end
                    if (all_fin)
                        drain_cnt <= DW'(PIPE_LAT - 1);
                end
                ST_DRAIN: drain_cnt <= drain_cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule
